// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: the buffered entry format
// and the exception codes carried alongside each instruction.
package fetch_queue_pkg;

  localparam logic [3:0] FQ_EXC_MISALIGNED = 4'd0;
  localparam logic [3:0] FQ_EXC_ACCESS     = 4'd1;

  typedef struct packed {
    logic        valid;
    logic [3:0]  code;
    logic [31:0] value;
  } fetch_exc_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    fetch_exc_t  exception;
  } fetch_entry_t;

  function automatic fetch_exc_t fq_exc(input logic [3:0] code, input logic [31:0] value);
    fetch_exc_t e;
    e.valid = 1'b1;
    e.code  = code;
    e.value = value;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally
// from the storage array so it stays stable until popped.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [AW:0]  o_count,
  output logic         o_empty
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

  // The issue credit in the parent guarantees neither of these can happen.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && r_count == FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && !i_flush && r_count == '0));

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: sequential PC, credit-limited one-word fetches,
// redirect flush and halt-on-exception. Optional FETCH_QUEUE_BYPASS_EN forwards
// a response straight to the head outputs when the FIFO is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_redirect_enable,
  input  logic [31:0] in_redirect_address,
  input  logic        in_inst_ready,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_exception_valid,
  output logic [3:0]  out_exception_code,
  output logic [31:0] out_exception_value,
  output logic        out_mem_fetch_enable,
  output logic [31:0] out_mem_fetch_address,
  input  logic [31:0] in_mem_fetch_data,
  input  logic        in_mem_fetch_exception
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CREDITS = (AW+2)'(DEPTH);

  logic [31:0]  r_pc;
  logic [31:0]  r_inflight_pc;
  logic [31:0]  r_mis_addr;
  logic         r_inflight;
  logic         r_halted;
  logic         r_mis_pending;

  logic         w_redirect_mis;
  logic         w_resp_valid;
  logic         w_bypass;
  logic         w_valid;
  logic         w_pop;
  logic         w_fifo_pop;
  logic         w_push;
  logic         w_issue;
  logic         w_fifo_empty;
  logic [AW:0]  w_count;
  logic [AW+1:0] w_used;
  logic [31:0]  w_issue_addr;
  fetch_entry_t w_resp_entry;
  fetch_entry_t w_mis_entry;
  fetch_entry_t w_push_data;
  fetch_entry_t w_fifo_head;
  fetch_entry_t w_head;
  fetch_entry_t w_out;

  assign w_redirect_mis = in_redirect_enable && (in_redirect_address[1:0] != 2'b00);
  // Responses are dropped on a redirect and once an exception has halted fetch.
  assign w_resp_valid   = r_inflight && !r_halted && !in_redirect_enable;

  always_comb begin
    w_resp_entry           = '0;
    w_resp_entry.pc        = r_inflight_pc;
    if (in_mem_fetch_exception) begin
      w_resp_entry.exception = fq_exc(FQ_EXC_ACCESS, r_inflight_pc);
    end else begin
      w_resp_entry.inst      = in_mem_fetch_data;
    end
    w_mis_entry            = '0;
    w_mis_entry.pc         = r_mis_addr;
    w_mis_entry.exception  = fq_exc(FQ_EXC_MISALIGNED, r_mis_addr);
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_fifo_empty && w_resp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head      = w_bypass ? w_resp_entry : w_fifo_head;
  assign w_valid     = !in_redirect_enable && (!w_fifo_empty || w_bypass);
  assign w_pop       = w_valid && in_inst_ready;
  assign w_fifo_pop  = w_pop && !w_fifo_empty;
  assign w_push      = !in_redirect_enable &&
                       (r_mis_pending || (w_resp_valid && !(w_bypass && w_pop)));
  assign w_push_data = r_mis_pending ? w_mis_entry : w_resp_entry;

  // Credit counts the entry leaving this cycle so DEPTH=2 still streams.
  assign w_used = {1'b0, w_count} + {{(AW+1){1'b0}}, r_inflight} - {{(AW+1){1'b0}}, w_pop};
  assign w_issue = reset && (in_redirect_enable ? !w_redirect_mis
                                                : (!r_halted && (w_used < CREDITS)));
  assign w_issue_addr = in_redirect_enable ? in_redirect_address : r_pc;

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (in_redirect_enable),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_count (w_count),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_mis_addr    <= '0;
      r_inflight    <= 1'b0;
      r_halted      <= 1'b0;
      r_mis_pending <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= w_issue_addr;
      if (in_redirect_enable) begin
        r_pc          <= in_redirect_address + 32'd4;
        r_halted      <= w_redirect_mis;
        r_mis_pending <= w_redirect_mis;
        r_mis_addr    <= in_redirect_address;
      end else begin
        r_mis_pending <= 1'b0;
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (w_resp_valid && in_mem_fetch_exception) r_halted <= 1'b1;
      end
    end
  end

  assign w_out = w_valid ? w_head : '0;

  assign out_inst_valid        = w_valid;
  assign out_inst              = w_out.inst;
  assign out_pc                = w_out.pc;
  assign out_exception_valid   = w_out.exception.valid;
  assign out_exception_code    = w_out.exception.code;
  assign out_exception_value   = w_out.exception.value;
  assign out_mem_fetch_enable  = w_issue;
  assign out_mem_fetch_address = w_issue ? w_issue_addr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all checked against a stream-level model of the expected deliveries.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        in_redirect_enable;
  logic [31:0] in_redirect_address;
  logic        in_inst_ready;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_exception_valid;
  logic [3:0]  out_exception_code;
  logic [31:0] out_exception_value;
  logic        out_mem_fetch_enable;
  logic [31:0] out_mem_fetch_address;
  logic [31:0] in_mem_fetch_data;
  logic        in_mem_fetch_exception;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_req = 1'b0;
  logic [31:0] m_addr = '0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = '0;

  // Stream model: next expected delivery and next expected issue address.
  logic [31:0] g_pc;
  logic        g_mis;
  logic        g_done;
  logic [31:0] m_issue_pc;
  logic        sb_exp_en;
  logic [100:0] sb_exp;
  logic [100:0] sb_got;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_redirect_enable    (in_redirect_enable),
    .in_redirect_address   (in_redirect_address),
    .in_inst_ready         (in_inst_ready),
    .out_inst_valid        (out_inst_valid),
    .out_inst              (out_inst),
    .out_pc                (out_pc),
    .out_exception_valid   (out_exception_valid),
    .out_exception_code    (out_exception_code),
    .out_exception_value   (out_exception_value),
    .out_mem_fetch_enable  (out_mem_fetch_enable),
    .out_mem_fetch_address (out_mem_fetch_address),
    .in_mem_fetch_data     (in_mem_fetch_data),
    .in_mem_fetch_exception(in_mem_fetch_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // Memory: answers exactly one cycle after each request.
  always @(negedge clk) begin
    m_req  = out_mem_fetch_enable;
    m_addr = out_mem_fetch_address;
  end

  always @(posedge clk) begin
    #1;
    if (m_req) begin
      in_mem_fetch_data      = mem_word(m_addr);
      in_mem_fetch_exception = fault_en && (m_addr == fault_addr);
    end else begin
      in_mem_fetch_data      = $urandom;
      in_mem_fetch_exception = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: runs for every cycle of every test.
  always @(negedge clk) begin
    if (!reset) begin
      g_pc       = RESET_PC;
      g_mis      = 1'b0;
      g_done     = 1'b0;
      m_issue_pc = RESET_PC;
    end else if (in_redirect_enable) begin
      n_cmp++;
      if (out_inst_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL sb_redirect_valid: got %b required 0", out_inst_valid);
      end
      sb_exp_en = (in_redirect_address[1:0] == 2'b00);
      n_cmp++;
      if (out_mem_fetch_enable !== sb_exp_en ||
          (sb_exp_en && out_mem_fetch_address !== in_redirect_address)) begin
        n_bad++;
        $display("FAIL sb_redirect_issue: got en=%b addr=%h required en=%b addr=%h",
                 out_mem_fetch_enable, out_mem_fetch_address, sb_exp_en, in_redirect_address);
      end
      m_issue_pc = in_redirect_address + 32'd4;
      g_pc       = in_redirect_address;
      g_mis      = !sb_exp_en;
      g_done     = 1'b0;
    end else begin
      if (out_mem_fetch_enable) begin
        n_cmp++;
        if (out_mem_fetch_address !== m_issue_pc) begin
          n_bad++;
          $display("FAIL sb_issue_addr: got %h required %h", out_mem_fetch_address, m_issue_pc);
        end
        m_issue_pc = m_issue_pc + 32'd4;
      end
      if (out_inst_valid && in_inst_ready) begin
        n_cmp++;
        if (g_done) begin
          n_bad++;
          $display("FAIL sb_extra_delivery: got pc %h required no delivery while halted", out_pc);
        end else begin
          if (g_mis)
            sb_exp = {32'h0, g_pc, 1'b1, 4'd0, g_pc};
          else if (fault_en && g_pc == fault_addr)
            sb_exp = {32'h0, g_pc, 1'b1, 4'd1, g_pc};
          else
            sb_exp = {mem_word(g_pc), g_pc, 1'b0, 4'd0, 32'h0};
          sb_got = {out_inst, out_pc, out_exception_valid, out_exception_code, out_exception_value};
          if (sb_got !== sb_exp) begin
            n_bad++;
            $display("FAIL sb_delivery: got %h required %h", sb_got, sb_exp);
          end
          if (sb_exp[36]) g_done = 1'b1;
          else            g_pc   = g_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that starts cycle 0.
  task automatic release_reset();
    reset = 1'b0;
    in_redirect_enable = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_inst_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({out_inst_valid, out_inst, out_pc, out_exception_valid, out_exception_code,
         out_exception_value, out_mem_fetch_enable, out_mem_fetch_address} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b pc=%h inst=%h en=%b addr=%h required all zero",
               out_inst_valid, out_pc, out_inst, out_mem_fetch_enable, out_mem_fetch_address);
    end
  endtask

  task automatic test_stream();
    logic exp_v;
    logic [31:0] exp_pc;
    in_inst_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_mem_fetch_enable !== 1'b1 || out_mem_fetch_address !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL stream_issue: cycle %0d got en=%b addr=%h required en=1 addr=%h",
                 i, out_mem_fetch_enable, out_mem_fetch_address, 32'(4 * i));
      end
      exp_v  = (i >= LAT);
      exp_pc = 32'(4 * (i - LAT));
      n_cmp++;
      if (out_inst_valid !== exp_v ||
          (exp_v && (out_pc !== exp_pc || out_inst !== mem_word(exp_pc)))) begin
        n_bad++;
        $display("FAIL stream_head: cycle %0d got valid=%b pc=%h required valid=%b pc=%h",
                 i, out_inst_valid, out_pc, exp_v, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_ready_low();
    int n_en;
    n_en = 0;
    in_inst_ready = 1'b0;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_mem_fetch_enable) n_en++;
      tick();
    end
    n_cmp++;
    if (n_en != DEPTH) begin
      n_bad++;
      $display("FAIL ready_low_issues: got %0d requests required %0d", n_en, DEPTH);
    end
    @(negedge clk);
    n_cmp++;
    if (out_inst_valid !== 1'b1 || out_pc !== 32'h0 || out_mem_fetch_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_low_hold: got valid=%b pc=%h en=%b required valid=1 pc=0 en=0",
               out_inst_valid, out_pc, out_mem_fetch_enable);
    end
    tick();
    in_inst_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b1 || out_mem_fetch_address !== 32'h10 || out_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL ready_resume: got en=%b addr=%h pc=%h required en=1 addr=10 pc=0",
               out_mem_fetch_enable, out_mem_fetch_address, out_pc);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (out_inst_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        n_bad++;
        $display("FAIL ready_drain: got valid=%b pc=%h required valid=1 pc=%h",
                 out_inst_valid, out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_flush();
    logic exp_v;
    logic [31:0] exp_pc;
    in_inst_ready = 1'b0;
    release_reset();
    repeat (4) tick();
    in_redirect_enable  = 1'b1;
    in_redirect_address = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b1 || out_mem_fetch_address !== 32'h100 || out_inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_issue: got en=%b addr=%h valid=%b required en=1 addr=100 valid=0",
               out_mem_fetch_enable, out_mem_fetch_address, out_inst_valid);
    end
    tick();
    in_redirect_enable = 1'b0;
    in_inst_ready      = 1'b1;
    for (int c = 5; c < 8; c++) begin
      @(negedge clk);
      exp_v  = (c >= 4 + LAT);
      exp_pc = 32'h100 + 32'(4 * (c - 4 - LAT));
      n_cmp++;
      if (out_inst_valid !== exp_v || (exp_v && out_pc !== exp_pc)) begin
        n_bad++;
        $display("FAIL flush_restart: cycle N+%0d got valid=%b pc=%h required valid=%b pc=%h",
                 c - 4, out_inst_valid, out_pc, exp_v, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    int n_en;
    int n_val;
    n_en = 0;
    n_val = 0;
    in_inst_ready = 1'b1;
    release_reset();
    repeat (5) tick();
    in_redirect_enable  = 1'b1;
    in_redirect_address = 32'h102;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b0 || out_inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_no_issue: got en=%b valid=%b required 0 0", out_mem_fetch_enable, out_inst_valid);
    end
    tick();
    in_redirect_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b0 || out_inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_n1: got en=%b valid=%b required 0 0", out_mem_fetch_enable, out_inst_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_inst_valid, out_exception_valid, out_exception_code, out_exception_value} !==
        {1'b1, 1'b1, 4'd0, 32'h102}) begin
      n_bad++;
      $display("FAIL mis_entry: got valid=%b exc=%b code=%0d value=%h required 1 1 0 102",
               out_inst_valid, out_exception_valid, out_exception_code, out_exception_value);
    end
    repeat (8) begin
      tick();
      @(negedge clk);
      if (out_mem_fetch_enable) n_en++;
      if (out_inst_valid) n_val++;
    end
    n_cmp++;
    if (n_en != 0 || n_val != 0) begin
      n_bad++;
      $display("FAIL mis_halted: got %0d requests %0d valid cycles required 0 0", n_en, n_val);
    end
    tick();
    in_redirect_enable  = 1'b1;
    in_redirect_address = 32'h200;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b1 || out_mem_fetch_address !== 32'h200) begin
      n_bad++;
      $display("FAIL mis_resume: got en=%b addr=%h required en=1 addr=200",
               out_mem_fetch_enable, out_mem_fetch_address);
    end
    tick();
    in_redirect_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_mem_fetch_enable !== 1'b1 || out_mem_fetch_address !== 32'h204) begin
      n_bad++;
      $display("FAIL mis_resume_next: got en=%b addr=%h required en=1 addr=204",
               out_mem_fetch_enable, out_mem_fetch_address);
    end
    repeat (4) tick();
  endtask

  task automatic test_fetch_exception();
    int n_del;
    int n_late;
    logic [100:0] rec [4];
    n_del = 0;
    n_late = 0;
    for (int k = 0; k < 4; k++) rec[k] = '0;
    fault_addr    = 32'h8;
    fault_en      = 1'b1;
    in_inst_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_inst_valid && in_inst_ready) begin
        if (n_del < 4)
          rec[n_del] = {out_inst, out_pc, out_exception_valid, out_exception_code, out_exception_value};
        n_del++;
      end
      if (i >= 4 && out_mem_fetch_enable) n_late++;
      tick();
    end
    n_cmp++;
    if (n_del != 3) begin
      n_bad++;
      $display("FAIL exc_count: got %0d deliveries required 3", n_del);
    end
    n_cmp++;
    if (rec[0] !== {mem_word(32'h0), 32'h0, 37'h0} || rec[1] !== {mem_word(32'h4), 32'h4, 37'h0}) begin
      n_bad++;
      $display("FAIL exc_prefix: got %h %h required pcs 0 and 4 without exception", rec[0], rec[1]);
    end
    n_cmp++;
    if (rec[2] !== {32'h0, 32'h8, 1'b1, 4'd1, 32'h8}) begin
      n_bad++;
      $display("FAIL exc_entry: got %h required access fault at 8", rec[2]);
    end
    n_cmp++;
    if (n_late != 0) begin
      n_bad++;
      $display("FAIL exc_halt: got %0d requests after halt required 0", n_late);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_wrap();
    int n_del;
    logic [31:0] pcs [3];
    n_del = 0;
    for (int k = 0; k < 3; k++) pcs[k] = 32'h1234_5678;
    in_inst_ready = 1'b1;
    release_reset();
    repeat (3) tick();
    in_redirect_enable  = 1'b1;
    in_redirect_address = 32'hFFFF_FFF8;
    tick();
    in_redirect_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_inst_valid && n_del < 3) begin
        pcs[n_del] = out_pc;
        n_del++;
      end
      tick();
    end
    n_cmp++;
    if (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_sequence: got %h %h %h required fffffff8 fffffffc 00000000",
               pcs[0], pcs[1], pcs[2]);
    end
  endtask

  task automatic test_reset_full();
    logic exp_v;
    in_inst_ready = 1'b0;
    release_reset();
    repeat (8) tick();
    @(negedge clk);
    n_cmp++;
    if (out_inst_valid !== 1'b1 || out_mem_fetch_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL rfull_setup: got valid=%b en=%b required 1 0", out_inst_valid, out_mem_fetch_enable);
    end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_inst_valid !== 1'b0 || out_mem_fetch_enable !== 1'b0 || out_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL rfull_async: got valid=%b en=%b pc=%h required 0 0 0",
               out_inst_valid, out_mem_fetch_enable, out_pc);
    end
    in_inst_ready = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = (i >= LAT);
      n_cmp++;
      if (out_mem_fetch_address !== RESET_PC + 32'(4 * i) || out_inst_valid !== exp_v ||
          (exp_v && out_pc !== RESET_PC + 32'(4 * (i - LAT)))) begin
        n_bad++;
        $display("FAIL rfull_restart: cycle %0d got addr=%h valid=%b pc=%h required addr=%h valid=%b",
                 i, out_mem_fetch_address, out_inst_valid, out_pc, RESET_PC + 32'(4 * i), exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int n_pop;
    int sel;
    n_pop = 0;
    fault_addr = 32'h1040;
    fault_en   = 1'b1;
    in_inst_ready = 1'b1;
    release_reset();
    for (int i = 0; i < 3000; i++) begin
      in_redirect_enable = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        in_redirect_enable = 1'b1;
        sel = $urandom_range(0, 7);
        if (sel == 0)
          in_redirect_address = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
        else if (sel == 1)
          in_redirect_address = 32'h1000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        else
          in_redirect_address = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      end
      in_inst_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_inst_valid && in_inst_ready) n_pop++;
      tick();
    end
    in_redirect_enable = 1'b0;
    fault_en = 1'b0;
    n_cmp++;
    if (n_pop < 300) begin
      n_bad++;
      $display("FAIL random_throughput: got %0d deliveries required at least 300", n_pop);
    end
  endtask

  initial begin
    reset                  = 1'b0;
    in_redirect_enable     = 1'b0;
    in_redirect_address    = '0;
    in_inst_ready          = 1'b1;
    in_mem_fetch_data      = '0;
    in_mem_fetch_exception = 1'b0;
    test_reset();
    test_stream();
    test_ready_low();
    test_redirect_flush();
    test_misaligned();
    test_fetch_exception();
    test_wrap();
    test_reset_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
